// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants and the multiply sequencer state type.
package alu_pkg;

  localparam int unsigned ALU_AND  = 0;
  localparam int unsigned ALU_SLT  = 1;
  localparam int unsigned ALU_OR   = 2;
  localparam int unsigned ALU_NOT  = 3;
  localparam int unsigned ALU_ADD  = 4;
  localparam int unsigned ALU_SUB  = 5;
  localparam int unsigned ALU_PASS = 6;
  localparam int unsigned ALU_BEQ  = 7;
  localparam int unsigned ALU_SRL  = 8;
  localparam int unsigned ALU_SRA  = 9;
  localparam int unsigned ALU_SLL  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU's ADD, one
// partial-product step per granted cycle. The product is {hi, lo}; the
// multiplier bits are consumed from lo[0] as the partial sum shifts in.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int reg_width = 8,
  parameter int op_width  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [reg_width-1:0]   mcand_in,
  input  logic [reg_width-1:0]   mplier_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*reg_width-1:0] prod_out,
  output logic                   alu_req,
  input  logic                   alu_gnt,
  output logic [reg_width-1:0]   alu_ra,
  output logic [reg_width-1:0]   alu_rb,
  output logic [op_width-1:0]    alu_op,
  input  logic [reg_width-1:0]   alu_res,
  input  logic [reg_width-1:0]   alu_car
);

  localparam int CW = $clog2(reg_width);

  seq_state_e           state_q, state_d;
  logic [reg_width-1:0] mcand_q, mcand_d;
  logic [reg_width-1:0] hi_q, hi_d;
  logic [reg_width-1:0] lo_q, lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Only the carry LSB carries information; the rest is folded away here.
  logic unused_car;
  assign unused_car = ^alu_car[reg_width-1:1];

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, step update and ALU request outputs.
  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    alu_req     = 1'b0;
    alu_ra      = '0;
    alu_rb      = '0;
    alu_op      = '0;
    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          mcand_d = mcand_in;
          hi_d    = '0;
          lo_d    = mplier_in;
          cnt_d   = '0;
          state_d = STEP;
        end
      end
      STEP: begin
        alu_req = 1'b1;
        alu_op  = op_width'(ALU_ADD);
        alu_ra  = hi_q;
        alu_rb  = lo_q[0] ? mcand_q : '0;
        // Without a grant the ALU result is someone else's; hold everything.
        if (alu_gnt) begin
          // {carry, sum, lo} >> 1: the carry lands in hi MSB, never dropped.
          {hi_d, lo_d} = {alu_car[0], alu_res, lo_q[reg_width-1:1]};
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == CW'(reg_width - 1)) state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign prod_out = {hi_q, lo_q};

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed and randomized checks of the ALU-sharing multiply sequencer.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  mcand_in, mplier_in;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] prod_out;
  logic        alu_req;
  logic        alu_gnt;
  logic [7:0]  alu_ra, alu_rb;
  logic [3:0]  alu_op;
  logic [7:0]  alu_res, alu_car;
  logic        gnt_en;
  logic [8:0]  sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.reg_width(8), .op_width(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .mcand_in(mcand_in), .mplier_in(mplier_in),
    .res_valid(res_valid), .res_ready(res_ready), .prod_out(prod_out),
    .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op),
    .alu_res(alu_res), .alu_car(alu_car)
  );

  // Small ALU model: ADD only; upper carry bits carry junk that must be ignored.
  always_comb begin
    sum = 9'h0;
    if (alu_op == 4'd4) sum = {1'b0, alu_ra} + {1'b0, alu_rb};
  end
  assign alu_res = sum[7:0];
  assign alu_car = {7'b1010101, sum[8]};
  assign alu_gnt = gnt_en & alu_req;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] mask;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    chk("start_ready_idle", 32'(start_ready), 1);
    start_valid = 1'b1;
    mcand_in    = a;
    mplier_in   = b;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    mcand_in    = 8'($urandom);
    mplier_in   = 8'($urandom);
  endtask

  // Drives gnt from mask (bit i = grant on the i-th STEP cycle) until res_valid.
  task automatic wait_result(input logic [31:0] mask, output logic [15:0] prod, output int lat);
    int idx = 0;
    logic [7:0] ra_s = 8'h0, rb_s = 8'h0;
    logic hold = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (hold && alu_req) begin
        chk("hold_ra", 32'(alu_ra), 32'(ra_s));
        chk("hold_rb", 32'(alu_rb), 32'(rb_s));
      end
      hold = 1'b0;
      if (res_valid) break;
      if (lat >= 200) begin
        chk("timeout", 32'(lat), 0);
        break;
      end
      if (alu_req) chk("alu_op_add", 32'(alu_op), 4);
      gnt_en = mask[idx % 32];
      if (!gnt_en) begin
        ra_s = alu_ra;
        rb_s = alu_rb;
        hold = 1'b1;
      end
      idx++;
      @(posedge clk);
      lat++;
    end
    gnt_en = 1'b1;
    prod   = prod_out;
  endtask

  // Holds off res_ready for rdy_wait cycles, then completes the handshake.
  task automatic finish_op(input int rdy_wait, input logic [15:0] prod);
    for (int i = 0; i < rdy_wait; i++) begin
      res_ready = 1'b0;
      chk("bp_prod_stable", 32'(prod_out), 32'(prod));
      chk("bp_start_ready", 32'(start_ready), 0);
      chk("bp_res_valid", 32'(res_valid), 1);
      chk("done_alu_req", 32'(alu_req), 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("done_alu_op_zero", 32'(alu_op), 0);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_res_valid", 32'(res_valid), 0);
    chk("post_hs_start_ready", 32'(start_ready), 1);
  endtask

  initial begin
    logic [15:0] p;
    int lat;
    logic [7:0] a, b;
    logic [31:0] m;

    vecs[0] = '{8'd3,   8'd5,   32'hFFFF_FFFF, 16'h000F, 8};
    vecs[1] = '{8'd255, 8'd255, 32'hFFFF_FFFF, 16'hFE01, 8};
    vecs[2] = '{8'd0,   8'd200, 32'hFFFF_FFFF, 16'h0000, 8};
    vecs[3] = '{8'd1,   8'd128, 32'hFFFF_FFFF, 16'h0080, 8};
    vecs[4] = '{8'd200, 8'd13,  ~32'h0000_0032, 16'h0A28, 11};
    vecs[5] = '{8'd17,  8'd19,  32'hFFFF_FFFF, 16'h0143, 8};
    vecs[6] = '{8'd128, 8'd255, 32'hFFFF_FFFF, 16'h7F80, 8};

    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0; gnt_en = 1'b1;
    mcand_in = 8'h0; mplier_in = 8'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_alu_req", 32'(alu_req), 0);
    chk("rst_prod_out", 32'(prod_out), 0);
    chk("rst_alu_ra", 32'(alu_ra), 0);

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(vecs[i].mask, p, lat);
      chk($sformatf("vec%0d_prod", i), 32'(p), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      finish_op((i == 0) ? 5 : 0, p);
    end

    // Result handshake and new start in the same DONE cycle: start waits a cycle.
    start_op(8'd6, 8'd7);
    wait_result(32'hFFFF_FFFF, p, lat);
    chk("overlap_first_prod", 32'(p), 32'd42);
    start_valid = 1'b1; mcand_in = 8'd9; mplier_in = 8'd11; res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    chk("overlap_idle_after_hs", 32'(start_ready), 1);
    chk("overlap_no_req", 32'(alu_req), 0);
    @(posedge clk);
    #1 start_valid = 1'b0; mcand_in = 8'hAA; mplier_in = 8'h55;
    wait_result(32'hFFFF_FFFF, p, lat);
    chk("overlap_second_prod", 32'(p), 32'd99);
    chk("overlap_second_lat", 32'(lat), 8);
    finish_op(0, p);

    // Reset after four steps of 17 x 19 discards the operation.
    start_op(8'd17, 8'd19);
    gnt_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_start_ready", 32'(start_ready), 1);
    chk("midrst_res_valid", 32'(res_valid), 0);
    chk("midrst_alu_req", 32'(alu_req), 0);
    chk("midrst_prod", 32'(prod_out), 0);
    start_op(8'd17, 8'd19);
    wait_result(32'hFFFF_FFFF, p, lat);
    chk("after_rst_prod", 32'(p), 32'h0143);
    finish_op(0, p);

    // Random operands, random grants and backpressure.
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      m = $urandom | 32'h8000_0001;
      start_op(a, b);
      wait_result(m, p, lat);
      chk("rand_prod", 32'(p), 32'(16'(a) * 16'(b)));
      finish_op(int'($urandom_range(0, 3)), p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle sequencer that computes an unsigned reg_width × reg_width → 2·reg_width product using the shared 8-bit ALU's ADD operation, one shift-and-add step per granted cycle. It sits beside the ALU and competes with the main datapath for ALU access. It requests the ALU through a req/gnt pair, and the top-level mux drives the ALU operands from this block while gnt is high. Operands enter and the product leaves on valid/ready handshakes.

## Interface
- reg_width, 8, operand width; ALU data width
- op_width, 4, ALU opcode width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- start_valid  in  1  operands valid
- start_ready  out  1  block can accept operands
- mcand_in  in  reg_width  multiplicand
- mplier_in  in  reg_width  multiplier
- res_valid  out  1  product valid
- res_ready  in  1  consumer accepts product
- prod_out  out  2·reg_width  product {hi, lo}
- alu_req  out  1  ALU requested this cycle
- alu_gnt  in  1  ALU granted this cycle; may be combinational from alu_req
- alu_ra  out  reg_width  ALU operand A
- alu_rb  out  reg_width  ALU operand B
- alu_op  out  op_width  ALU opcode
- alu_res  in  reg_width  ALU result
- alu_car  in  reg_width  ALU carry output; only bit 0 is used

## Operation
- Registers: state, mcand (reg_width), hi (reg_width), lo (reg_width), cnt ($clog2(reg_width) bits).
- States:
  - IDLE: start_ready=1. On start_valid: mcand←mcand_in, hi←0, lo←mplier_in, cnt←0, →STEP.
  - STEP: alu_req=1, alu_op=4 (ADD), alu_ra=hi, alu_rb = lo[0] ? mcand : 0.
    - If alu_gnt: {hi, lo} ← {alu_car[0], alu_res, lo} >> 1, cnt←cnt+1. When cnt==reg_width−1, go →DONE.
    - If !alu_gnt: all registers hold.
  - DONE: res_valid=1, prod_out={hi, lo}. On res_ready, →IDLE.
- Outputs outside STEP:
  - alu_req=0.
  - alu_ra, alu_rb and alu_op are driven 0.
- prod_out is held stable while res_valid=1 and res_ready=0.
- Result is exact: no overflow is possible, because the 2·reg_width product fits.
- The add carry enters hi[reg_width−1] during the shift. It is never dropped.
- start_ready is asserted only in IDLE, so there is no back-to-back accept. The minimum gap is one IDLE cycle after the result handshake.
- Operand values on mcand_in and mplier_in are ignored outside the accept cycle.

## Timing
- Reset, on an edge with rst_n=0:
  - state=IDLE; mcand, hi, lo and cnt = 0.
  - Next cycle: start_ready=1, res_valid=0, alu_req=0, prod_out=0.
- Reset mid-operation, in STEP or DONE: the operation is discarded with no result emitted. The block is in IDLE the next cycle.
- Latency with alu_gnt held 1:
  - Accept at edge E0.
  - Steps at edges E1..E8.
  - res_valid=1 in the cycle after E8.
- Each low-gnt cycle in STEP adds exactly one cycle of latency.
- alu_res and alu_car are sampled only at an edge where state==STEP and alu_gnt=1.
- Simultaneous result handshake and start_valid in DONE: the start is not accepted, because start_ready=0. It is accepted in the following IDLE cycle.
- cnt wraps to 0 at the DONE transition and is reloaded on accept.

## Structure
- Shared package alu_pkg holds:
  - ALU opcode constants: ALU_AND=0, ALU_SLT=1, ALU_OR=2, ALU_NOT=3, ALU_ADD=4, ALU_SUB=5, ALU_PASS=6, ALU_BEQ=7, ALU_SRL=8, ALU_SRA=9, ALU_SLL=10.
  - The sequencer state enum {IDLE, STEP, DONE}.
- No sub-module. The shift-and-add step is a single registered update.
- ALU/datapath muxing lives in the top level, not here.

## Test plan
- 3 × 5, gnt always 1 → prod_out=0x000F; res_valid exactly 8 cycles after the accept edge.
- 255 × 255 → prod_out=0xFE01, exercising the alu_car[0] shift-in; 0 × 200 → 0x0000; 1 × 128 → 0x0080.
- 200 × 13 with alu_gnt low on steps 2, 5 and 6 → prod_out=0x0A28; res_valid at cycle 11; registers unchanged on non-granted cycles.
- Result backpressure: res_ready low for 5 cycles in DONE → prod_out stable and start_ready=0 throughout; IDLE one cycle after the handshake.
- Reset after step 4 of 17 × 19 → next cycle IDLE, res_valid=0, alu_req=0; a following 17 × 19 gives 0x0143.
- Random operands (≥1000), random gnt and res_ready → prod_out equals the reference product; alu_op=4 whenever alu_req=1.
